intra_ram_dp_param: RTL and testbench

//  Parametrised single-clock dual-port SRAM for intra reference line/column buffers
//  (successor to the fixed 32x480 intra buffers). Adds byte-masked writes, same-address

---
 rtl/intra_ram_dp_param_pkg.sv | 17 +
 rtl/intra_ram_dp_param_core.sv | 50 +++++
 rtl/intra_ram_dp_param.sv | 199 +++++++++++++++++++
 tb/tb_intra_ram_dp_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_ram_dp_param_pkg.sv
// Shared constants and types for the parametrised intra reference line/column buffer.
package intra_ram_dp_param_pkg;

    localparam int unsigned INTRA_BUF_WORD_WIDTH = 32;
    localparam int unsigned INTRA_BUF_DEPTH      = 480;
    localparam int unsigned INTRA_BUF_ADDR_WIDTH = 9;

    // Legal read latency settings
    localparam int unsigned RD_LAT_1 = 1;
    localparam int unsigned RD_LAT_2 = 2;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/intra_ram_dp_param_core.sv
// Plain two-port word array with per-port enable, byte mask and 1-cycle registered read.
// On a same-address double write, port A's masked bytes take priority over port B's.
module intra_ram_dp_core
    import intra_ram_dp_param_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = INTRA_BUF_WORD_WIDTH,
    parameter int unsigned DEPTH      = INTRA_BUF_DEPTH,
    parameter int unsigned ADDR_WIDTH = INTRA_BUF_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      ena_i,
    input  logic                      wea_i,
    input  logic [ADDR_WIDTH-1:0]     addra_i,
    input  logic [WORD_WIDTH/8-1:0]   maska_i,
    input  logic [WORD_WIDTH-1:0]     dataa_i,
    output logic [WORD_WIDTH-1:0]     qa_o,
    input  logic                      enb_i,
    input  logic                      web_i,
    input  logic [ADDR_WIDTH-1:0]     addrb_i,
    input  logic [WORD_WIDTH/8-1:0]   maskb_i,
    input  logic [WORD_WIDTH-1:0]     datab_i,
    output logic [WORD_WIDTH-1:0]     qb_o
);

    localparam int unsigned NB = WORD_WIDTH / 8;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] qa_q;
    logic [WORD_WIDTH-1:0] qb_q;

    // Port A's byte writes are issued last so they override port B's on collision
    always_ff @(posedge clk) begin
        if (enb_i && web_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (maskb_i[b]) mem_q[addrb_i][b*8 +: 8] <= datab_i[b*8 +: 8];
            end
        end
        if (ena_i && wea_i) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (maska_i[b]) mem_q[addra_i][b*8 +: 8] <= dataa_i[b*8 +: 8];
            end
        end
        if (ena_i && !wea_i) qa_q <= mem_q[addra_i];
        if (enb_i && !web_i) qb_q <= mem_q[addrb_i];
    end

    assign qa_o = qa_q;
    assign qb_o = qb_q;

endmodule

// File: rtl/intra_ram_dp_param.sv
// Dual-port intra reference buffer: clear engine, range check, collision bypass and
// 1/2-cycle read pipeline wrapped around a swappable two-port array core.
module intra_ram_dp_param
    import intra_ram_dp_param_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = INTRA_BUF_WORD_WIDTH,
    parameter int unsigned DEPTH       = INTRA_BUF_DEPTH,
    parameter int unsigned ADDR_WIDTH  = INTRA_BUF_ADDR_WIDTH,
    parameter int unsigned RD_LAT      = RD_LAT_1,
    parameter int unsigned WRITE_FIRST = 1,
    parameter int unsigned CLR_ON_RST  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    output logic                      busy_o,
    output logic                      err_o,
    input  logic                      cena_i,
    input  logic                      wena_i,
    input  logic [ADDR_WIDTH-1:0]     addra_i,
    input  logic [WORD_WIDTH/8-1:0]   maska_i,
    input  logic [WORD_WIDTH-1:0]     dataa_i,
    output logic [WORD_WIDTH-1:0]     dataa_o,
    input  logic                      cenb_i,
    input  logic                      wenb_i,
    input  logic [ADDR_WIDTH-1:0]     addrb_i,
    input  logic [WORD_WIDTH/8-1:0]   maskb_i,
    input  logic [WORD_WIDTH-1:0]     datab_i,
    output logic [WORD_WIDTH-1:0]     datab_o
);

    localparam int unsigned NB = WORD_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam clr_state_e RST_STATE = (CLR_ON_RST != 0) ? CLR_CLEAR : CLR_IDLE;

    clr_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  busy;

    logic a_act, a_inr, a_rd, a_wr;
    logic b_act, b_inr, b_rd, b_wr;

    logic                    core_ena, core_wea, core_enb, core_web;
    logic [ADDR_WIDTH-1:0]   core_addra;
    logic [NB-1:0]           core_maska;
    logic [WORD_WIDTH-1:0]   core_dataa;
    logic [WORD_WIDTH-1:0]   core_qa, core_qb;

    logic                  s1a_vld_q, s1a_vld_d, s1b_vld_q, s1b_vld_d;
    logic                  s1a_oor_q, s1a_oor_d, s1b_oor_q, s1b_oor_d;
    logic [NB-1:0]         s1a_bym_q, s1a_bym_d, s1b_bym_q, s1b_bym_d;
    logic [WORD_WIDTH-1:0] s1a_byd_q, s1a_byd_d, s1b_byd_q, s1b_byd_d;
    logic [WORD_WIDTH-1:0] outa_q, outa_d, outb_q, outb_d;
    logic [WORD_WIDTH-1:0] rda_word, rdb_word;

    assign busy  = (state_q == CLR_CLEAR);
    assign a_act = !cena_i && !busy;
    assign b_act = !cenb_i && !busy;
    assign a_inr = (32'(addra_i) < DEPTH);
    assign b_inr = (32'(addrb_i) < DEPTH);
    assign a_rd  = a_act && wena_i;
    assign a_wr  = a_act && !wena_i;
    assign b_rd  = b_act && wenb_i;
    assign b_wr  = b_act && !wenb_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_i) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (clr_i && !busy) err_d = 1'b0;
        else if ((a_act && !a_inr) || (b_act && !b_inr)) err_d = 1'b1;
    end

    // The clear engine borrows core port A; port B is simply gated while busy
    always_comb begin
        core_ena   = a_act && a_inr;
        core_wea   = !wena_i;
        core_addra = addra_i;
        core_maska = maska_i;
        core_dataa = dataa_i;
        if (busy) begin
            core_ena   = 1'b1;
            core_wea   = 1'b1;
            core_addra = cnt_q;
            core_maska = '1;
            core_dataa = '0;
        end
        core_enb = b_act && b_inr;
        core_web = !wenb_i;
    end

    // Cross-port write data captured with the read so it can be merged over the stale core word
    always_comb begin
        s1a_vld_d = a_rd;
        s1a_oor_d = !a_inr;
        s1a_bym_d = '0;
        s1a_byd_d = datab_i;
        s1b_vld_d = b_rd;
        s1b_oor_d = !b_inr;
        s1b_bym_d = '0;
        s1b_byd_d = dataa_i;
        if (WRITE_FIRST != 0) begin
            if (a_rd && b_wr && a_inr && (addra_i == addrb_i)) s1a_bym_d = maskb_i;
            if (b_rd && a_wr && b_inr && (addra_i == addrb_i)) s1b_bym_d = maska_i;
        end
    end

    always_comb begin
        rda_word = core_qa;
        rdb_word = core_qb;
        for (int unsigned i = 0; i < NB; i++) begin
            if (s1a_bym_q[i]) rda_word[i*8 +: 8] = s1a_byd_q[i*8 +: 8];
            if (s1b_bym_q[i]) rdb_word[i*8 +: 8] = s1b_byd_q[i*8 +: 8];
        end
        if (s1a_oor_q) rda_word = '0;
        if (s1b_oor_q) rdb_word = '0;
        outa_d = s1a_vld_q ? rda_word : outa_q;
        outb_d = s1b_vld_q ? rdb_word : outb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            s1a_vld_q <= 1'b0;
            s1a_oor_q <= 1'b0;
            s1a_bym_q <= '0;
            s1a_byd_q <= '0;
            s1b_vld_q <= 1'b0;
            s1b_oor_q <= 1'b0;
            s1b_bym_q <= '0;
            s1b_byd_q <= '0;
            outa_q    <= '0;
            outb_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            s1a_vld_q <= s1a_vld_d;
            s1a_oor_q <= s1a_oor_d;
            s1a_bym_q <= s1a_bym_d;
            s1a_byd_q <= s1a_byd_d;
            s1b_vld_q <= s1b_vld_d;
            s1b_oor_q <= s1b_oor_d;
            s1b_bym_q <= s1b_bym_d;
            s1b_byd_q <= s1b_byd_d;
            outa_q    <= outa_d;
            outb_q    <= outb_d;
        end
    end

    // RD_LAT=1 bypasses the output register on the completing cycle; it still provides the hold value
    assign dataa_o = (RD_LAT == RD_LAT_1 && s1a_vld_q) ? rda_word : outa_q;
    assign datab_o = (RD_LAT == RD_LAT_1 && s1b_vld_q) ? rdb_word : outb_q;
    assign busy_o  = busy;
    assign err_o   = err_q;

    intra_ram_dp_core #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk     (clk),
        .ena_i   (core_ena),
        .wea_i   (core_wea),
        .addra_i (core_addra),
        .maska_i (core_maska),
        .dataa_i (core_dataa),
        .qa_o    (core_qa),
        .enb_i   (core_enb),
        .web_i   (core_web),
        .addrb_i (addrb_i),
        .maskb_i (maskb_i),
        .datab_i (datab_i),
        .qb_o    (core_qb)
    );

endmodule

// File: tb/tb_intra_ram_dp_param.sv
// Scoreboard bench: two instances (RD_LAT=1/WRITE_FIRST=1 and RD_LAT=2/WRITE_FIRST=0)
// share stimulus; expected reads are queued with their due cycle and checked by a monitor.
module tb_intra_ram_dp_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        cena = 1'b1, wena = 1'b1, cenb = 1'b1, wenb = 1'b1;
    logic [8:0]  addra = '0, addrb = '0;
    logic [3:0]  maska = '0, maskb = '0;
    logic [31:0] dataa = '0, datab = '0;

    logic        busy1, err1, busy2, err2;
    logic [31:0] qa1, qb1, qa2, qb2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          due;
        int          dut;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    intra_ram_dp_param #(
        .WORD_WIDTH(32), .DEPTH(480), .ADDR_WIDTH(9),
        .RD_LAT(1), .WRITE_FIRST(1), .CLR_ON_RST(1)
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy1), .err_o(err1),
        .cena_i(cena), .wena_i(wena), .addra_i(addra), .maska_i(maska), .dataa_i(dataa), .dataa_o(qa1),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .maskb_i(maskb), .datab_i(datab), .datab_o(qb1)
    );

    intra_ram_dp_param #(
        .WORD_WIDTH(32), .DEPTH(480), .ADDR_WIDTH(9),
        .RD_LAT(2), .WRITE_FIRST(0), .CLR_ON_RST(1)
    ) u_lat2 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy2), .err_o(err2),
        .cena_i(cena), .wena_i(wena), .addra_i(addra), .maska_i(maska), .dataa_i(dataa), .dataa_o(qa2),
        .cenb_i(cenb), .wenb_i(wenb), .addrb_i(addrb), .maskb_i(maskb), .datab_i(datab), .datab_o(qb2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dout(input int d, input int p);
        if (d == 1) return (p == 0) ? qa1 : qb1;
        return (p == 0) ? qa2 : qb2;
    endfunction

    // Monitor: compare every entry that falls due on this cycle
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due <= cyc) chk(sb[i].name, dout(sb[i].dut, sb[i].port), sb[i].val);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    end

    task automatic push(input int dut, input int port, input int delta, input logic [31:0] v, input string nm);
        exp_t e;
        e.due  = cyc + delta;
        e.dut  = dut;
        e.port = port;
        e.val  = v;
        e.name = $sformatf("%s_d%0d_%s", nm, dut, (port == 0) ? "a" : "b");
        sb.push_back(e);
    endtask

    // Expect a read issued this cycle to appear after each instance's latency
    task automatic exp_rd(input int port, input logic [31:0] v1, input logic [31:0] v2, input string nm);
        push(1, port, 1, v1, nm);
        push(2, port, 2, v2, nm);
    endtask

    task automatic idle();
        cena = 1'b1; wena = 1'b1; addra = '0; maska = '0; dataa = '0;
        cenb = 1'b1; wenb = 1'b1; addrb = '0; maskb = '0; datab = '0;
    endtask

    task automatic rd_a(input logic [8:0] ad);
        cena = 1'b0; wena = 1'b1; addra = ad;
    endtask
    task automatic rd_b(input logic [8:0] ad);
        cenb = 1'b0; wenb = 1'b1; addrb = ad;
    endtask
    task automatic wr_a(input logic [8:0] ad, input logic [3:0] m, input logic [31:0] d);
        cena = 1'b0; wena = 1'b0; addra = ad; maska = m; dataa = d;
    endtask
    task automatic wr_b(input logic [8:0] ad, input logic [3:0] m, input logic [31:0] d);
        cenb = 1'b0; wenb = 1'b0; addrb = ad; maskb = m; datab = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Count busy cycles per instance; optionally hammer ports during busy or pulse clr at clr_at
    task automatic count_busy(output int n1, output int n2, input bit drive, input int clr_at);
        n1 = 0;
        n2 = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy1 && !busy2) break;
            if (busy1) n1++;
            if (busy2) n2++;
            clr = (n1 == clr_at);
            if (drive) begin
                chk("busy_hold_qa1", qa1, 32'h0);
                chk("busy_hold_qb1", qb1, 32'h0);
                chk("busy_hold_qa2", qa2, 32'h0);
                chk("busy_hold_qb2", qb2, 32'h0);
                wr_a(9'd3, 4'hF, 32'hFFFF_FFFF);
                if (k[0]) rd_b(9'd480);
                else rd_b(9'd3);
            end
        end
        clr = 1'b0;
        idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2;
        idle();

        // 1: reset state, power-up clear length, cleared contents
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy1", 32'(busy1), 32'h1);
        chk("rst_busy2", 32'(busy2), 32'h1);
        chk("rst_err1", 32'(err1), 32'h0);
        chk("rst_err2", 32'(err2), 32'h0);
        chk("rst_qa1", qa1, 32'h0);
        chk("rst_qb2", qb2, 32'h0);
        rst_n = 1'b1;
        count_busy(n1, n2, 1'b0, -1);
        chk("pwrup_busy_len1", 32'(n1), 32'd480);
        chk("pwrup_busy_len2", 32'(n2), 32'd480);
        rd_a(9'd0); rd_b(9'd479);
        exp_rd(0, 32'h0, 32'h0, "clr_addr0");
        exp_rd(1, 32'h0, 32'h0, "clr_addr479");
        step();

        // 2: byte-masked write, read on the other port, both ports read the same word
        wr_a(9'd5, 4'hF, 32'h1122_3344); step();
        wr_a(9'd5, 4'b0101, 32'hDEAD_BEEF); step();
        rd_a(9'd5); rd_b(9'd5);
        exp_rd(0, 32'h11AD_33EF, 32'h11AD_33EF, "mask_wr");
        exp_rd(1, 32'h11AD_33EF, 32'h11AD_33EF, "mask_wr");
        step();

        // 3: same-address double write; writing ports hold their outputs
        wr_a(9'd7, 4'b1100, 32'hAAAA_AAAA); wr_b(9'd7, 4'b1111, 32'h5555_5555); step();
        push(1, 0, 0, 32'h11AD_33EF, "wr_hold"); push(1, 1, 0, 32'h11AD_33EF, "wr_hold");
        push(2, 0, 0, 32'h11AD_33EF, "wr_hold"); push(2, 1, 0, 32'h11AD_33EF, "wr_hold");
        step();
        rd_a(9'd7);
        exp_rd(0, 32'hAAAA_5555, 32'hAAAA_5555, "dual_wr");
        step();
        push(1, 0, 2, 32'hAAAA_5555, "idle_hold");
        push(2, 0, 2, 32'hAAAA_5555, "idle_hold");
        step();

        // 4: read/write collision on opposite ports
        wr_a(9'd9, 4'hF, 32'h1234_5678); rd_b(9'd9);
        exp_rd(1, 32'h1234_5678, 32'h0, "coll_a_wr");
        step();
        wr_b(9'd10, 4'b0011, 32'hCAFE_F00D); rd_a(9'd10);
        exp_rd(0, 32'h0000_F00D, 32'h0, "coll_b_wr");
        step();
        wr_a(9'd9, 4'b1000, 32'hFF00_0000); rd_b(9'd9);
        exp_rd(1, 32'hFF34_5678, 32'h1234_5678, "coll_merge");
        step();
        rd_a(9'd10);
        exp_rd(0, 32'h0000_F00D, 32'h0000_F00D, "after_coll");
        step();

        // 5: out-of-range access, sticky err, clear on demand (clr during busy ignored)
        cena = 1'b1; wena = 1'b0; addra = 9'd500; step();
        chk("cen_idle_err1", 32'(err1), 32'h0);
        chk("cen_idle_err2", 32'(err2), 32'h0);
        rd_a(9'd480);
        exp_rd(0, 32'h0, 32'h0, "oor_rd");
        step();
        chk("oor_err1", 32'(err1), 32'h1);
        chk("oor_err2", 32'(err2), 32'h1);
        repeat (3) step();
        chk("oor_err_held1", 32'(err1), 32'h1);
        chk("oor_err_held2", 32'(err2), 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_err1", 32'(err1), 32'h0);
        chk("clr_busy1", 32'(busy1), 32'h1);
        chk("clr_busy2", 32'(busy2), 32'h1);
        count_busy(n1, n2, 1'b0, 100);
        chk("clr_busy_len1", 32'(n1), 32'd480);
        chk("clr_busy_len2", 32'(n2), 32'd480);
        rd_a(9'd5); rd_b(9'd7);
        exp_rd(0, 32'h0, 32'h0, "after_clr");
        exp_rd(1, 32'h0, 32'h0, "after_clr");
        step();

        // 6: reset part-way through a clear; ports ignored during the restarted clear
        wr_a(9'd3, 4'hF, 32'h0BAD_F00D); step();
        rd_a(9'd3); rd_b(9'd3);
        exp_rd(0, 32'h0BAD_F00D, 32'h0BAD_F00D, "pre_rst");
        exp_rd(1, 32'h0BAD_F00D, 32'h0BAD_F00D, "pre_rst");
        step();
        step();
        clr = 1'b1; step(); clr = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy1", 32'(busy1), 32'h1);
        chk("mid_rst_busy2", 32'(busy2), 32'h1);
        chk("mid_rst_qa1", qa1, 32'h0);
        chk("mid_rst_qb1", qb1, 32'h0);
        chk("mid_rst_qa2", qa2, 32'h0);
        chk("mid_rst_qb2", qb2, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_busy(n1, n2, 1'b1, -1);
        chk("restart_busy_len1", 32'(n1), 32'd480);
        chk("restart_busy_len2", 32'(n2), 32'd480);
        chk("busy_no_err1", 32'(err1), 32'h0);
        chk("busy_no_err2", 32'(err2), 32'h0);
        rd_a(9'd3); rd_b(9'd3);
        exp_rd(0, 32'h0, 32'h0, "post_rst_addr3");
        exp_rd(1, 32'h0, 32'h0, "post_rst_addr3");
        step();

        repeat (4) step();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
